dm_responder: RTL and testbench



---
 rtl/dm_pkg.sv | 22 ++
 rtl/dm_sram_array.sv | 50 +++++
 rtl/dm_responder.sv | 147 ++++++++++++++
 tb/tb_dm_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared FSM encoding, lane/counter constants and range helper for dm_responder
package dm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dm_state_e;

   localparam int DM_LANES = 4;
   localparam int DM_CNT_W = 4;

   // True when a byte address falls outside the window of 2^depth_log2 words starting at base.
   function automatic logic dm_oor(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input int          depth_log2);
      logic [31:0] off;
      off = addr - base;
      return (addr < base) || ((off >> (depth_log2 + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/dm_sram_array.sv
// rtl/dm_sram_array.sv - word RAM with byte-lane writes, registered read, optional DM_DEBUG_PORT_EN async read
module dm_sram_array
   import dm_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [DM_LANES-1:0]   we_i,
   input  logic [31:0]           wdata_i,
   input  logic                  re_i,
   input  logic                  rclr_i,
`ifdef DM_DEBUG_PORT_EN
   input  logic [DEPTH_LOG2-1:0] dbg_idx_i,
   output logic [31:0]           dbg_word_o,
`endif
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [2**DEPTH_LOG2];
   logic [31:0] rdata_q;

   // Byte-lane writes; storage itself is never reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DM_LANES; i++) begin
         if (we_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   // Read register holds its value until the next read or clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (rclr_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

`ifdef DM_DEBUG_PORT_EN
   assign dbg_word_o = mem_q[dbg_idx_i];
`endif

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - MEM-stage data-memory responder with wait states; DM_DEBUG_PORT_EN adds a debug read port
module dm_responder
   import dm_pkg::*;
#(
   parameter int          DEPTH_LOG2  = 8,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        dm_req,
   input  logic [31:0] dm_addr,
   input  logic [3:0]  dm_wen,
   input  logic [31:0] dm_wdata,
`ifdef DM_DEBUG_PORT_EN
   input  logic [31:0] dbg_addr,
   output logic [31:0] dbg_rdata,
`endif
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        dm_err
);

   dm_state_e             state_q, state_d;
   logic [DM_CNT_W-1:0]   cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [DM_LANES-1:0]   wen_q, wen_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  oor_q, oor_d;

   logic [DEPTH_LOG2-1:0] req_idx, acc_idx;
   logic                  req_oor, acc_oor;
   logic [DM_LANES-1:0]   acc_wen, mem_we;
   logic [31:0]           acc_wdata;
   logic                  mem_re, mem_rclr;

   assign req_idx = DEPTH_LOG2'((dm_addr - BASE_ADDR) >> 2);
   assign req_oor = dm_oor(dm_addr, BASE_ADDR, DEPTH_LOG2);

   // With zero wait states the access happens on the accept edge, so use the live request then.
   assign acc_idx   = (state_q == ST_IDLE) ? req_idx  : idx_q;
   assign acc_oor   = (state_q == ST_IDLE) ? req_oor  : oor_q;
   assign acc_wen   = (state_q == ST_IDLE) ? dm_wen   : wen_q;
   assign acc_wdata = (state_q == ST_IDLE) ? dm_wdata : wdata_q;

   // State and latched-request registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wen_q   <= '0;
         wdata_q <= '0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         oor_q   <= oor_d;
      end
   end

   // Next-state: accept only in IDLE, count down wait states, single RESP cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      oor_d   = oor_q;
      unique case (state_q)
         ST_IDLE: begin
            if (dm_req) begin
               idx_d   = req_idx;
               wen_d   = dm_wen;
               wdata_d = dm_wdata;
               oor_d   = req_oor;
               if (WAIT_CYCLES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = DM_CNT_W'(WAIT_CYCLES - 1);
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs and memory strobes; the access fires on the edge that enters RESP.
   always_comb begin
      dm_ready = 1'b0;
      dm_err   = 1'b0;
      mem_we   = '0;
      mem_re   = 1'b0;
      mem_rclr = 1'b0;
      if (state_q == ST_RESP) begin
         dm_ready = 1'b1;
         dm_err   = oor_q;
      end
      if (resetn && state_d == ST_RESP && state_q != ST_RESP) begin
         // Any out-of-range access, read or write, returns zero data and writes nothing.
         if (acc_oor) begin
            mem_rclr = 1'b1;
         end else if (acc_wen == '0) begin
            mem_re = 1'b1;
         end else begin
            mem_we = acc_wen;
         end
      end
   end

`ifdef DM_DEBUG_PORT_EN
   logic [DEPTH_LOG2-1:0] dbg_idx;
   logic [31:0]           dbg_word;
   assign dbg_idx   = DEPTH_LOG2'((dbg_addr - BASE_ADDR) >> 2);
   assign dbg_rdata = dm_oor(dbg_addr, BASE_ADDR, DEPTH_LOG2) ? 32'h0 : dbg_word;
`endif

   dm_sram_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_sram (
      .clk_i     (clk),
      .rst_ni    (resetn),
      .addr_i    (acc_idx),
      .we_i      (mem_we),
      .wdata_i   (acc_wdata),
      .re_i      (mem_re),
      .rclr_i    (mem_rclr),
`ifdef DM_DEBUG_PORT_EN
      .dbg_idx_i (dbg_idx),
      .dbg_word_o(dbg_word),
`endif
      .rdata_o   (dm_rdata)
   );

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - self-checking bench for dm_responder against a word-array reference model
module tb_dm_responder;

   localparam int          DL     = 8;
   localparam int          DEPTH  = 1 << DL;
   localparam int          WAITC  = 1;
   localparam logic [31:0] LIMIT  = 32'h0000_0400;

   logic        clk = 1'b0;
   logic        resetn;
   logic        dm_req;
   logic [31:0] dm_addr;
   logic [3:0]  dm_wen;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        dm_err;
`ifdef DM_DEBUG_PORT_EN
   logic [31:0] dbg_addr = 32'h0;
   logic [31:0] dbg_rdata;
`endif

   always #5 clk = ~clk;

   dm_responder #(
      .DEPTH_LOG2 (DL),
      .WAIT_CYCLES(WAITC),
      .BASE_ADDR  (32'h0)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .dm_req   (dm_req),
      .dm_addr  (dm_addr),
      .dm_wen   (dm_wen),
      .dm_wdata (dm_wdata),
`ifdef DM_DEBUG_PORT_EN
      .dbg_addr (dbg_addr),
      .dbg_rdata(dbg_rdata),
`endif
      .dm_rdata (dm_rdata),
      .dm_ready (dm_ready),
      .dm_err   (dm_err)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: word contents, which bytes are known, and the expected held read data.
   logic [31:0] ref_mem   [DEPTH];
   logic [3:0]  ref_known [DEPTH];
   logic [31:0] ref_rdata;
   logic [31:0] ref_rmask;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_access(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                               output logic exp_err);
      int idx;
      idx = int'(addr >> 2);
      if (addr >= LIMIT) begin
         exp_err   = 1'b1;
         ref_rdata = 32'h0;
         ref_rmask = 32'hFFFF_FFFF;
      end else begin
         exp_err = 1'b0;
         if (wen == 4'b0000) begin
            ref_rdata = ref_mem[idx];
            for (int i = 0; i < 4; i++) ref_rmask[8*i +: 8] = {8{ref_known[idx][i]}};
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (wen[i]) begin
                  ref_mem[idx][8*i +: 8] = wdata[8*i +: 8];
                  ref_known[idx][i]      = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic do_access(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                            input string tag);
      int   edges;
      bit   got;
      logic exp_err;
      model_access(addr, wen, wdata, exp_err);
      @(negedge clk);
      dm_req   = 1'b1;
      dm_addr  = addr;
      dm_wen   = wen;
      dm_wdata = wdata;
      edges = 0;
      got   = 1'b0;
      while (!got && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
         if (dm_ready === 1'b1) got = 1'b1;
         else if (edges == 1) begin
            dm_addr  = $urandom();
            dm_wen   = 4'($urandom());
            dm_wdata = $urandom();
         end
      end
      check({tag, ":ready"}, 32'(got), 32'd1);
      check({tag, ":latency"}, 32'(edges), 32'(WAITC + 1));
      check({tag, ":err"}, 32'(dm_err), 32'(exp_err));
      check({tag, ":rdata"}, dm_rdata & ref_rmask, ref_rdata & ref_rmask);
      dm_req = 1'b0;
      @(posedge clk);
      #1;
      check({tag, ":pulse"}, {30'd0, dm_ready, dm_err}, 32'd0);
   endtask

   initial begin
      logic        e;
      logic [31:0] a;
      logic [3:0]  w;

      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i]   = 32'h0;
         ref_known[i] = 4'h0;
      end
      ref_rdata = 32'h0;
      ref_rmask = 32'hFFFF_FFFF;

      resetn   = 1'b0;
      dm_req   = 1'b0;
      dm_addr  = 32'h0;
      dm_wen   = 4'h0;
      dm_wdata = 32'h0;
      #20;
      check("reset_rdata", dm_rdata, 32'h0);
      check("reset_ready", 32'(dm_ready), 32'd0);
      check("reset_err", 32'(dm_err), 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Full-word write then read back.
      do_access(32'h10, 4'b1111, 32'hCCCC_CCCC, "wr_full");
      do_access(32'h10, 4'b0000, 32'h0, "rd_full");
      check("plan_full_word", dm_rdata, 32'hCCCC_CCCC);

      // Single byte lane.
      do_access(32'h10, 4'b0100, 32'h00AB_0000, "wr_lane2");
      do_access(32'h13, 4'b0000, 32'h0, "rd_lane2");
      check("plan_lane_word", dm_rdata, 32'hCCAB_CCCC);

      // Out of range read and write; word 0 must survive.
      do_access(32'h0, 4'b1111, 32'h5A5A_0001, "wr_w0");
      do_access(32'h400, 4'b0000, 32'h0, "rd_oor");
      check("plan_oor_rdata", dm_rdata, 32'h0);
      do_access(32'h400, 4'b1111, 32'hFFFF_FFFF, "wr_oor");
      do_access(32'h0, 4'b0000, 32'h0, "rd_w0");
      check("plan_w0_kept", dm_rdata, 32'h5A5A_0001);

      // Held request: one pulse per 2+WAIT cycles, never back to back.
      model_access(32'h10, 4'b0000, 32'h0, e);
      @(negedge clk);
      dm_req  = 1'b1;
      dm_addr = 32'h10;
      dm_wen  = 4'b0000;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("held_ready_%0d", k), 32'(dm_ready), 32'((k % (2 + WAITC)) == (1 + WAITC)));
         check($sformatf("held_err_%0d", k), 32'(dm_err), 32'd0);
      end
      dm_req = 1'b0;
      check("held_rdata", dm_rdata, 32'hCCAB_CCCC);
      @(posedge clk);
      @(posedge clk);

      // Reset while a write waits: nothing committed, no pulse.
      do_access(32'h20, 4'b1111, 32'h1111_1111, "wr_pre");
      @(negedge clk);
      dm_req   = 1'b1;
      dm_addr  = 32'h20;
      dm_wen   = 4'b1111;
      dm_wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      resetn = 1'b0;
      dm_req = 1'b0;
      #1;
      check("midrst_ready", 32'(dm_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("midrst_ready_hold", 32'(dm_ready), 32'd0);
      end
      @(negedge clk);
      resetn    = 1'b1;
      ref_rdata = 32'h0;
      ref_rmask = 32'hFFFF_FFFF;
      check("midrst_rdata", dm_rdata, 32'h0);
      do_access(32'h20, 4'b0000, 32'h0, "rd_after_rst");
      check("plan_midrst_kept", dm_rdata, 32'h1111_1111);

      // Randomised accesses against the model.
      for (int n = 0; n < 60; n++) begin
         a = 32'($urandom_range(0, 32'h4FF));
         if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h8000_0000;
         w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         do_access(a, w, $urandom(), $sformatf("rnd%0d", n));
      end

`ifdef DM_DEBUG_PORT_EN
      do_access(32'h8, 4'b1111, 32'hDEAD_BEEF, "wr_dbg");
      dbg_addr = 32'h8;
      #1;
      check("dbg_word", dbg_rdata, 32'hDEAD_BEEF);
      dbg_addr = 32'h400;
      #1;
      check("dbg_oor", dbg_rdata, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
